vram_arbiter: RTL and testbench

Single-port framebuffer arbiter between the display pixel fetch and game-logic writes. Sits between the sync generator (hcount, vcount, inDispArea) and a synchronous 1-cycle-read block RAM holding a 160x120 cell map; each cell covers 4x4 screen pixels. Display reads always win their slot. Game-logic writes are queued in a small FIFO and drained in every cycle the display does not need the RAM.

---
 rtl/vram_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Purpose:
//   Shares one synchronous, single-port block RAM (160x120 cell map, one cell
//   per 4x4 screen pixels) between the display pixel fetch and game-logic
//   writes. Display reads always own their slot. Game-logic writes are
//   buffered in a small circular FIFO and drained in every cycle that the
//   display does not need the RAM.
//
// Slot rule, evaluated every cycle from the inputs of that cycle:
//   read slot  : inDispArea == 1 and hcount[1:0] == 0
//   write slot : every other cycle, used only when the FIFO holds an entry
//
// Write handshake (valid/ready):
//   A push happens in a cycle where wr_req and wr_ready are both high.
//   wr_ready is "FIFO not full" and comes only from registered state.
//   wr_req while wr_ready is low drops that entry.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   hcount, vcount      - sync-generator counters (0..793, 0..527)
//   inDispArea          - sync-generator active-video flag
//   wr_req/wr_addr/wr_data/wr_ready - game-logic write port
//   mem_addr/mem_we/mem_wdata       - registered RAM command outputs
//   mem_rdata           - RAM read data, valid one cycle after mem_addr
//   pix_data/pix_valid  - cell colour for the current pixel, 2 clocks late
//   wr_ovf              - sticky overflow flag (only with VRAM_OVF_FLAG_EN)
//
// Configuration:
//   VRAM_OVF_FLAG_EN - when defined, adds the wr_ovf output, which sets on
//                      any cycle with wr_req=1 and wr_ready=0 and stays set
//                      until reset. When undefined, drops are silent.
//
// Parameters:
//   DATA_W     - bits per cell
//   FIFO_DEPTH - write-queue entries; power of two, at least 2
//   ADDR_W     - RAM address width; fixed by the 160x120 map, do not override
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              inDispArea,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
`ifdef VRAM_OVF_FLAG_EN
    output logic              wr_ovf,
`endif
    output logic              pix_valid
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;

    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Read-slot flag and inDispArea, each delayed by two clocks so they line
    // up with the cycle in which the RAM presents the fetched cell.
    logic              rd_flag1_q,  rd_flag2_q;
    logic              disp1_q,     disp2_q;

    // Last fetched cell colour, shown for the three non-fetch pixels of a cell.
    logic [DATA_W-1:0] hold_q,      hold_d;

`ifdef VRAM_OVF_FLAG_EN
    logic              ovf_q,       ovf_d;
`endif

    // -------------------------------------------------------------------------
    // Slot decision and FIFO status
    // -------------------------------------------------------------------------
    logic              read_slot;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign read_slot  = inDispArea && (hcount[1:0] == 2'b00);

    assign wr_idx     = wr_ptr_q[IDX_W-1:0];
    assign rd_idx     = rd_ptr_q[IDX_W-1:0];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_idx == rd_idx);

    // Full/empty come from registered pointers only: an entry pushed this
    // cycle cannot be popped this cycle (no bypass), and a pop this cycle does
    // not free a slot for a push this cycle.
    assign push       = wr_req && !fifo_full;
    assign pop        = !read_slot && !fifo_empty;

    // -------------------------------------------------------------------------
    // Display read address: row*160 + col as shifts and adds at ADDR_W bits.
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] row_w;
    logic [ADDR_W-1:0] col_w;
    logic [ADDR_W-1:0] rd_addr_w;

    assign row_w     = ADDR_W'(vcount[9:2]);
    assign col_w     = ADDR_W'(hcount[9:2]);
    assign rd_addr_w = (row_w << 7) + (row_w << 5) + col_w;

    // vcount[1:0] selects a pixel row within a cell and never affects the RAM.
    logic unused_vcount_lsbs;
    assign unused_vcount_lsbs = ^vcount[1:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (read_slot) begin
            mem_addr_d = rd_addr_w;
        end else if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            mem_addr_d  = fifo_addr_q[rd_idx];
            mem_wdata_d = fifo_data_q[rd_idx];
            mem_we_d    = 1'b1;
        end

        if (rd_flag2_q) begin
            hold_d = mem_rdata;
        end
    end

`ifdef VRAM_OVF_FLAG_EN
    always_comb begin
        ovf_d = ovf_q;
        if (wr_req && fifo_full) begin
            ovf_d = 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_flag1_q  <= 1'b0;
            rd_flag2_q  <= 1'b0;
            disp1_q     <= 1'b0;
            disp2_q     <= 1'b0;
            hold_q      <= '0;
`ifdef VRAM_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd_flag1_q  <= read_slot;
            rd_flag2_q  <= rd_flag1_q;
            disp1_q     <= inDispArea;
            disp2_q     <= disp1_q;
            hold_q      <= hold_d;
`ifdef VRAM_OVF_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // FIFO storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_addr_q[wr_idx] <= wr_addr;
            fifo_data_q[wr_idx] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign wr_ready  = !fifo_full;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_valid = disp2_q;

    // On the fetch pixel the RAM output register already holds the new cell,
    // so it is passed straight through; the other three pixels of the cell
    // show the captured copy. Outside active video the colour is black.
    assign pix_data  = !disp2_q   ? '0        :
                       rd_flag2_q ? mem_rdata : hold_q;

`ifdef VRAM_OVF_FLAG_EN
    assign wr_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 15;
  localparam int E_W    = ADDR_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        hcount = '0;
  logic [9:0]        vcount = '0;
  logic              inDispArea = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
`ifdef VRAM_OVF_FLAG_EN
  logic              wr_ovf;
`endif

  always #5 clock = ~clock;

  vram_arbiter #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .inDispArea (inDispArea),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
`ifdef VRAM_OVF_FLAG_EN
    .wr_ovf     (wr_ovf),
`endif
    .pix_valid  (pix_valid)
  );

  // Power-on contents of a cell that has never been written.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 7 + 1;
    return t[DATA_W-1:0];
  endfunction

  // Block RAM behind the DUT: 1-cycle synchronous read, read-first.
  bit [DATA_W-1:0] ram     [1 << ADDR_W];
  bit              ram_vld [1 << ADDR_W];

  always @(posedge clock) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr]     <= mem_wdata;
      ram_vld[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [E_W-1:0]      exp_q[$];     // queued writes, {addr, data}
  logic [DATA_W:0]     pix_q[$];     // {valid, data} per future cycle
  bit   [DATA_W-1:0]   m_ram     [1 << ADDR_W];
  bit                  m_ram_vld [1 << ADDR_W];

  logic              e_we     = 1'b0;
  logic [ADDR_W-1:0] e_addr   = '0;
  logic [DATA_W-1:0] e_wdata  = '0;
  logic              e_ovf    = 1'b0;
  logic [DATA_W-1:0] last_rd  = '0;
  bit                have_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Predicts the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    bit             push_ok;
    int             row;
    int             col;
    logic [ADDR_W-1:0] ra;
    logic [E_W-1:0] e;
    if (reset) begin
      exp_q.delete();
      pix_q.delete();
      pix_q.push_back('0);
      pix_q.push_back('0);
      e_we    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_ovf   = 1'b0;
      last_rd = '0;
      return;
    end
    push_ok = wr_req && (exp_q.size() < DEPTH);
    if (wr_req && !push_ok) e_ovf = 1'b1;
    if (inDispArea && (hcount % 4 == 0)) begin
      row    = vcount / 4;
      col    = hcount / 4;
      ra     = ADDR_W'(row * 160 + col);
      e_addr = ra;
      e_we   = 1'b0;
      last_rd = m_ram_vld[ra] ? m_ram[ra] : init_val(ra);
    end else if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      e_addr  = e[E_W-1:DATA_W];
      e_wdata = e[DATA_W-1:0];
      e_we    = 1'b1;
      m_ram[e_addr]     = e_wdata;
      m_ram_vld[e_addr] = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    pix_q.push_back({inDispArea, inDispArea ? last_rd : '0});
    if (push_ok) exp_q.push_back({wr_addr, wr_data});
  endtask

  task automatic check_outputs();
    logic [DATA_W:0] p;
    if (have_exp) begin
      check_eq("wr_ready", wr_ready, exp_q.size() < DEPTH);
      check_eq("mem_we", mem_we, e_we);
      check_eq("mem_addr", mem_addr, e_addr);
      if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
      p = pix_q.pop_front();
      check_eq("pix_valid", pix_valid, p[DATA_W]);
      check_eq("pix_data", pix_data, p[DATA_W-1:0]);
`ifdef VRAM_OVF_FLAG_EN
      check_eq("wr_ovf", wr_ovf, e_ovf);
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input logic rst, input logic disp, input int hc, input int vc,
                      input logic req, input int a, input int d);
    @(negedge clock);
    check_outputs();
    reset      = rst;
    inDispArea = disp;
    hcount     = 10'(hc);
    vcount     = 10'(vc);
    wr_req     = req;
    wr_addr    = ADDR_W'(a);
    wr_data    = DATA_W'(d);
    model_step();
    have_exp   = 1'b1;
  endtask

  function automatic int rnd_addr();
    return int'($urandom_range(0, 19199));
  endfunction

  function automatic int rnd_data();
    return int'($urandom_range(0, (1 << DATA_W) - 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int mode;

    // Power-on reset.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);

    // Blanking writes: (100,3) lands two cycles later; (162,5) prepares a read.
    step(0, 0, 700, 500, 1, 100, 3);
    step(0, 0, 701, 500, 0, 0, 0);
    step(0, 0, 702, 500, 1, 162, 5);
    for (int i = 0; i < 4; i++) step(0, 0, 703 + i, 500, 0, 0, 0);

    // Read addressing: row 1, col 2 -> cell 162, shown for hcount 8..11.
    for (int h = 4; h < 20; h++) step(0, 1, h, 4, 0, 0, 0);

    // Fill under a continuous read-slot stream, then overflow and drop.
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 4 * i, 40, 1, rnd_addr(), rnd_data());
    step(0, 1, 64, 40, 1, rnd_addr(), rnd_data());
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 650 + i, 490, 0, 0, 0);

    // Occupancy 4, then push and pop together for a few cycles.
    for (int i = 0; i < 4; i++) step(0, 1, 8 * i, 60, 1, rnd_addr(), rnd_data());
    for (int i = 0; i < 3; i++) step(0, 0, 660 + i, 490, 1, rnd_addr(), rnd_data());
    for (int i = 0; i < 8; i++) step(0, 0, 670 + i, 490, 0, 0, 0);

    // One full line with writes scattered across active video and blanking.
    for (int h = 0; h < 794; h++)
      step(0, h < 640, h, 10, 1'($urandom_range(0, 1)), rnd_addr(), rnd_data());
    for (int i = 0; i < 10; i++) step(0, 0, i, 11, 0, 0, 0);

    // Reset mid-frame with three queued writes and a request during reset.
    for (int i = 0; i < 3; i++) step(0, 1, 4 * i, 80, 1, rnd_addr(), rnd_data());
    step(1, 1, 12, 80, 1, rnd_addr(), rnd_data());
    step(1, 1, 13, 80, 1, rnd_addr(), rnd_data());
    for (int i = 0; i < 6; i++) step(0, 0, 700 + i, 80, 0, 0, 0);

    // Randomized traffic in mixed modes, with occasional resets.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 48 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0: step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 793)), int'($urandom_range(0, 527)),
                1'($urandom_range(0, 1)), rnd_addr(), rnd_data());
        1: step(0, 1, 4 * int'($urandom_range(0, 159)), int'($urandom_range(0, 479)),
                $urandom_range(0, 3) != 0, rnd_addr(), rnd_data());
        default: step(0, 0, int'($urandom_range(640, 793)), int'($urandom_range(480, 527)),
                      $urandom_range(0, 3) == 0, rnd_addr(), rnd_data());
      endcase
    end
    for (int i = 0; i < 12; i++) step(0, 0, 700 + i, 500, 0, 0, 0);

    @(negedge clock);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
